// File: rtl/pcie_tl_pkg.sv
// Shared constants for the transaction-layer VC pop arbiter: sizing defaults
// and FSM state encodings.
package pcie_tl_pkg;

    localparam int unsigned PKG_NUM_REQ = 4;
    localparam int unsigned PKG_DATA_W  = 10;
    localparam int unsigned IDX_W       = 2;
    localparam int unsigned BURST_W     = 3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_XFER  = 2'd2;

endpackage

// File: rtl/vc_pop_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority winner select. The search starts
// one past the last grant and wraps, so last = NUM_REQ-1 gives fixed priority
// with requester 0 highest.
module rr_pick
    import pcie_tl_pkg::*;
#(
    parameter int unsigned NUM_REQ = PKG_NUM_REQ
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] win,
    output logic [IDX_W-1:0]   win_idx,
    output logic               found
);

    logic [IDX_W-1:0] cand;

    // First requester found walking upward from last+1, modulo NUM_REQ.
    always_comb begin
        win     = '0;
        win_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'(32'(last) + i);
            if (!found && req[cand]) begin
                found     = 1'b1;
                win[cand] = 1'b1;
                win_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/vc_pop_arbiter.sv
// vc_pop_arbiter: pops words from NUM_REQ requester FIFOs into one downstream
// FIFO. Round-robin grants with bursts of up to MAX_BURST words.
// Build option STRICT_PRIO_EN: fixed priority (requester 0 highest) with
// re-arbitration after every word; MAX_BURST is then not used.
module vc_pop_arbiter
    import pcie_tl_pkg::*;
#(
    parameter int unsigned NUM_REQ   = PKG_NUM_REQ,
    parameter int unsigned DATA_W    = PKG_DATA_W,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                      clk,
    input  logic                      reset_L,
    input  logic                      enable,
    input  logic [NUM_REQ-1:0]        fifo_empty,
    input  logic [NUM_REQ*DATA_W-1:0] fifo_data,
    input  logic                      dest_almost_full,
    output logic [NUM_REQ-1:0]        fifo_pop,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_push,
    output logic [1:0]                grant_id,
    output logic                      busy
);

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [IDX_W-1:0]   grant_nxt;
    logic [BURST_W-1:0] burst_cnt;
    logic [BURST_W-1:0] burst_nxt;
    logic [BURST_W-1:0] burst_inc;
    logic [IDX_W-1:0]   pop_idx;
    logic [NUM_REQ-1:0] req;
    logic               any_req;
    logic               pop_en;
    logic [IDX_W-1:0]   pick_last;
    logic [NUM_REQ-1:0] pick_win;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_found;

    assign req       = ~fifo_empty;
    assign any_req   = |req;
    assign burst_inc = burst_cnt + BURST_W'(1);

`ifdef STRICT_PRIO_EN
    assign pick_last = IDX_W'(NUM_REQ - 1);
`else
    assign pick_last = grant_id;
`endif

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req     (req),
        .last    (pick_last),
        .win     (pick_win),
        .win_idx (pick_idx),
        .found   (pick_found)
    );

    // Pop is decided in the same cycle from live flags so an emptied FIFO is
    // never popped and a burst runs at one word per cycle.
    assign pop_en   = (state == ST_XFER) && enable && !dest_almost_full
                      && !fifo_empty[grant_id];
    assign fifo_pop = pop_en ? (NUM_REQ'(1) << grant_id) : '0;
    assign busy     = (state != ST_IDLE);

    // Read data arrives the cycle after the pop, aligned with out_push.
    assign out_data = out_push ? fifo_data[int'(pop_idx)*DATA_W +: DATA_W] : '0;

    // Next-state, grant and burst-count decode.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant_id;
        burst_nxt = burst_cnt;
        case (state)
            ST_IDLE: begin
                if (enable && any_req) begin
                    state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (enable && pick_found) begin
                    grant_nxt = pick_idx;
                    burst_nxt = '0;
                    state_nxt = ST_XFER;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (!enable || !any_req) begin
                    state_nxt = ST_IDLE;
                end else if (!dest_almost_full) begin
                    if (pop_en) begin
                        burst_nxt = burst_inc;
`ifdef STRICT_PRIO_EN
                        state_nxt = ST_GRANT;
`else
                        if (burst_inc == BURST_W'(MAX_BURST)) begin
                            state_nxt = ST_GRANT;
                        end
`endif
                    end else begin
                        // granted FIFO drained while another still holds data
                        state_nxt = ST_GRANT;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, grant pointer, burst count and push pipeline registers.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state     <= ST_IDLE;
            grant_id  <= IDX_W'(NUM_REQ - 1);
            burst_cnt <= '0;
            out_push  <= 1'b0;
            pop_idx   <= '0;
        end else begin
            state     <= state_nxt;
            grant_id  <= grant_nxt;
            burst_cnt <= burst_nxt;
            out_push  <= pop_en;
            if (pop_en) begin
                pop_idx <= grant_id;
            end
        end
    end

    logic unused_ok;
    assign unused_ok = &{1'b0, pick_win};

endmodule

// File: doc/vc_pop_arbiter.md
VC_POP_ARBITER -- requirements
Module: vc_pop_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning the number of requester FIFOs (fixed at 4 in this release).
REQ-002 SHALL have parameter DATA_W, default 10, meaning the FIFO word width.
REQ-003 SHALL have parameter MAX_BURST, default 4, meaning the maximum consecutive pops granted to one requester, range 1-7.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on posedge.
REQ-005 SHALL have port reset_L, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port enable, input, 1 bit: arbitration allowed (system ACTIVE state).
REQ-007 SHALL have port fifo_empty, input, NUM_REQ bits: per-requester FIFO empty flags.
REQ-008 SHALL have port fifo_data, input, NUM_REQ*DATA_W bits: per-FIFO read data, valid 1 cycle after its pop.
REQ-009 SHALL have port dest_almost_full, input, 1 bit: downstream FIFO cannot accept more words.
REQ-010 SHALL have port fifo_pop, output, NUM_REQ bits: one-hot pop strobes.
REQ-011 SHALL have port out_data, output, DATA_W bits: word forwarded downstream.
REQ-012 SHALL have port out_push, output, 1 bit: out_data valid; push downstream.
REQ-013 SHALL have port grant_id, output, 2 bits: index of the current or last granted requester.
REQ-014 SHALL have port busy, output, 1 bit: FSM not in IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, GRANT, XFER.
REQ-016 SHALL transition IDLE->GRANT when enable=1 and any fifo_empty bit is 0; otherwise stay in IDLE.
REQ-017 SHALL, in GRANT, select the winner by round-robin, searching from (grant_id+1) mod 4 upward, and register it into grant_id; burst counter cleared; GRANT->XFER.
REQ-018 SHALL, in XFER, assert fifo_pop[grant_id] for the cycle only when fifo_empty[grant_id]=0, dest_almost_full=0 and enable=1.
REQ-019 SHALL assert out_push exactly 1 cycle after each pop, with out_data = fifo_data slice of the popped requester, registered.
REQ-020 SHALL leave XFER to GRANT when the burst count reaches MAX_BURST, or when the granted FIFO is empty and another is non-empty.
REQ-021 SHALL leave XFER to IDLE when all FIFOs are empty or enable=0; a pending out_push from the final pop still completes.
REQ-022 SHALL treat dest_almost_full=1 as a stall in XFER: no pop, no state change, burst count held.
REQ-023 SHALL never assert more than one fifo_pop bit, and never pop an empty FIFO.
REQ-024 SHALL wrap the round-robin pointer from 3 to 0.
REQ-025 SHALL allow sustained throughput of 1 word/cycle within a burst.

Reset
REQ-026 SHALL, while reset_L=0, force state=IDLE, fifo_pop=0, out_push=0, out_data=0, grant_id=3 (so requester 0 wins first), busy=0, and burst count=0.
REQ-027 SHALL discard any in-flight word when reset is asserted mid-burst; no out_push follows reset release.

Configuration
REQ-028 SHALL, when macro STRICT_PRIO_EN is defined, replace round-robin with fixed priority (0 highest) and ignore MAX_BURST, re-arbitrating after every word; without the macro, REQ-017/REQ-020 apply.

Structure
REQ-029 SHALL take state encodings, NUM_REQ and DATA_W defaults from a shared package/include (pcie_tl_pkg).
REQ-030 SHALL place winner selection in sub-module rr_pick (request vector + last grant -> one-hot winner, index), purely combinational.

Verification
REQ-031 Reset: reset_L=0 mid-burst -> next cycle fifo_pop=0, out_push=0, grant_id=3, busy=0.
REQ-032 Fairness: all 4 FIFOs hold 8 words, MAX_BURST=4 -> grant order 0,1,2,3,0..., 4 pushes each per turn, 32 total out_push.
REQ-033 Backpressure: dest_almost_full=1 for 5 cycles mid-burst -> zero pops during those cycles, transfer resumes, no word lost or duplicated.
REQ-034 Empty skip: only FIFO 2 non-empty, holding 3 words -> grant_id=2, 3 pops, 3 pushes with matching data, then IDLE.
REQ-035 Wrap: grant_id=3, FIFOs 0 and 3 non-empty -> next grant 0.
REQ-036 STRICT_PRIO_EN build: FIFO 0 refilled continuously -> FIFO 1 never granted while FIFO 0 is non-empty.
